nios_avalon_st_error_pipe_adapter: RTL and testbench

NIOS_AVALON_ST_ERROR_PIPE_ADAPTER -- requirements
Module: nios_avalon_st_error_pipe_adapter

---
 rtl/nios_avalon_st_error_pipe_adapter.sv | 126 ++++++++++++
 tb/tb_nios_avalon_st_error_pipe_adapter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/nios_avalon_st_error_pipe_adapter.sv
// Avalon-ST pipeline stage with a two-entry skid buffer that remaps the error
// field (direct or masked OR) and optionally accumulates errors across a packet.
module nios_avalon_st_error_pipe_adapter #(
  parameter int                  DATA_W     = 32,
  parameter int                  EMPTY_W    = 2,
  parameter int                  IN_ERR_W   = 6,
  parameter int                  OUT_ERR_W  = 1,
  parameter int                  ERR_MODE   = 0,
  parameter logic [IN_ERR_W-1:0] ERR_MASK   = '1,
  parameter int                  PKT_STICKY = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  output logic                 in_ready,
  input  logic                 in_valid,
  input  logic [DATA_W-1:0]    in_data,
  input  logic [IN_ERR_W-1:0]  in_error,
  input  logic                 in_startofpacket,
  input  logic                 in_endofpacket,
  input  logic [EMPTY_W-1:0]   in_empty,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [DATA_W-1:0]    out_data,
  output logic [OUT_ERR_W-1:0] out_error,
  output logic                 out_startofpacket,
  output logic                 out_endofpacket,
  output logic [EMPTY_W-1:0]   out_empty,
  output logic [15:0]          err_beat_count
);

  typedef struct packed {
    logic [DATA_W-1:0]    data;
    logic [OUT_ERR_W-1:0] err;
    logic                 sop;
    logic                 eop;
    logic [EMPTY_W-1:0]   empty;
  } beat_t;

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_t;

  state_t               state, state_nxt;
  beat_t                main_q, skid_q, in_beat;
  logic [OUT_ERR_W-1:0] mapped, stored, acc;
  logic                 in_acc, out_acc;
  logic                 load_main, load_skid, skid_to_main;
  logic                 err_unused;

  assign in_acc  = in_valid & in_ready;
  assign out_acc = out_valid & out_ready;

  // Input error bits beyond the output width are intentionally dropped in direct mode.
  assign err_unused = ^in_error;

  if (ERR_MODE == 0) begin : g_direct
    for (genvar i = 0; i < OUT_ERR_W; i++) begin : g_bit
      if (i < IN_ERR_W) begin : g_map
        assign mapped[i] = in_error[i];
      end else begin : g_zero
        assign mapped[i] = 1'b0;
      end
    end
  end else begin : g_or
    assign mapped = {OUT_ERR_W{|(in_error & ERR_MASK)}};
  end

  // A start-of-packet beat always restarts accumulation, even without a prior eop.
  assign stored  = (PKT_STICKY != 0 && !in_startofpacket) ? (acc | mapped) : mapped;
  assign in_beat = {in_data, stored, in_startofpacket, in_endofpacket, in_empty};

  always_comb begin
    state_nxt    = state;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    case (state)
      S_EMPTY: if (in_acc) begin
        state_nxt = S_ONE;
        load_main = 1'b1;
      end
      S_ONE: begin
        if (in_acc && !out_acc) begin
          state_nxt = S_FULL;
          load_skid = 1'b1;
        end else if (in_acc && out_acc) begin
          load_main = 1'b1;
        end else if (out_acc) begin
          state_nxt = S_EMPTY;
        end
      end
      S_FULL: if (out_acc) begin
        state_nxt    = S_ONE;
        skid_to_main = 1'b1;
      end
      default: state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= S_EMPTY;
      main_q         <= '0;
      skid_q         <= '0;
      acc            <= '0;
      in_ready       <= 1'b0;
      out_valid      <= 1'b0;
      err_beat_count <= '0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt != S_FULL);
      out_valid <= (state_nxt != S_EMPTY);
      if (load_main)         main_q <= in_beat;
      else if (skid_to_main) main_q <= skid_q;
      if (load_skid)         skid_q <= in_beat;
      if (in_acc)            acc    <= in_endofpacket ? '0 : stored;
      if (out_acc && (|out_error) && (err_beat_count != 16'hFFFF))
        err_beat_count <= err_beat_count + 16'd1;
    end
  end

  assign out_data          = main_q.data;
  assign out_error         = main_q.err;
  assign out_startofpacket = main_q.sop;
  assign out_endofpacket   = main_q.eop;
  assign out_empty         = main_q.empty;

endmodule

// File: tb/tb_nios_avalon_st_error_pipe_adapter.sv
// Bench for the error pipe adapter: three configurations share one stimulus
// stream; a queue-based model predicts every beat, error and in_ready/out_valid.
module tb_nios_avalon_st_error_pipe_adapter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic [5:0]  in_error = '0;
  logic        in_sop = 1'b0, in_eop = 1'b0;
  logic [1:0]  in_empty = '0;
  logic        out_ready = 1'b0;

  logic        rdy  [3];
  logic        ov   [3];
  logic [31:0] od   [3];
  logic [0:0]  oe   [3];
  logic        osop [3];
  logic        oeop [3];
  logic [1:0]  oemp [3];
  logic [15:0] cnt  [3];

  always #5 clk = ~clk;

  // d0: direct map, d1: masked OR with mask 110000, d2: direct map + packet sticky
  for (genvar k = 0; k < 3; k++) begin : g_dut
    nios_avalon_st_error_pipe_adapter #(
      .ERR_MODE  ((k == 1) ? 1 : 0),
      .ERR_MASK  ((k == 1) ? 6'b110000 : 6'b111111),
      .PKT_STICKY((k == 2) ? 1 : 0)
    ) u_dut (
      .clk(clk), .reset_n(reset_n),
      .in_ready(rdy[k]), .in_valid(in_valid), .in_data(in_data), .in_error(in_error),
      .in_startofpacket(in_sop), .in_endofpacket(in_eop), .in_empty(in_empty),
      .out_ready(out_ready), .out_valid(ov[k]), .out_data(od[k]), .out_error(oe[k]),
      .out_startofpacket(osop[k]), .out_endofpacket(oeop[k]), .out_empty(oemp[k]),
      .err_beat_count(cnt[k])
    );
  end

  typedef struct packed {
    logic [31:0] d;
    logic [2:0]  e;
    logic        s;
    logic        p;
    logic [1:0]  m;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0, n_fail = 0;
  int   ecnt[3];
  logic acc2 = 1'b0;
  logic pend = 1'b0;
  logic post_rst = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: error rules applied at input acceptance, beats queued in order.
  function automatic void push(input logic [31:0] d, input logic [5:0] e,
                               input logic s, input logic p, input logic [1:0] m);
    exp_t x;
    logic e2;
    e2   = s ? e[0] : (acc2 | e[0]);
    acc2 = p ? 1'b0 : e2;
    x.d = d; x.e = {e2, |(e & 6'b110000), e[0]}; x.s = s; x.p = p; x.m = m;
    sb.push_back(x);
  endfunction

  task automatic cycle(input logic v, input logic [31:0] d, input logic [5:0] e,
                       input logic s, input logic p, input logic [1:0] m,
                       input logic ordy, output logic acc);
    @(negedge clk); #1;
    in_valid = v; in_data = d; in_error = e; in_sop = s; in_eop = p; in_empty = m;
    out_ready = ordy;
    acc  = v && rdy[0] && reset_n;
    pend = acc;
    if (acc) push(d, e, s, p, m);
  endtask

  task automatic idle(input logic ordy);
    logic a;
    cycle(1'b0, '0, '0, 1'b0, 1'b0, '0, ordy, a);
  endtask

  task automatic send(input logic [31:0] d, input logic [5:0] e, input logic s,
                      input logic p, input logic ordy);
    logic a;
    int   n;
    a = 1'b0;
    n = 0;
    while (!a && n < 50) begin
      cycle(1'b1, d, e, s, p, 2'(d), ordy, a);
      n++;
    end
    n_tests++;
    if (!a) begin
      n_fail++;
      $display("FAIL send timeout: beat %0h not accepted within 50 cycles", d);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    reset_n = 1'b0; in_valid = 1'b0; pend = 1'b0;
    @(negedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("d%0d reset out_valid", k), 32'(ov[k]), 0);
      chk($sformatf("d%0d reset in_ready", k), 32'(rdy[k]), 0);
      chk($sformatf("d%0d reset count", k), 32'(cnt[k]), 0);
      chk($sformatf("d%0d reset fields", k),
          32'({od[k] != 0, oe[k], osop[k], oeop[k], oemp[k]}), 0);
    end
    sb.delete();
    acc2 = 1'b0;
    for (int k = 0; k < 3; k++) ecnt[k] = 0;
    reset_n  = 1'b1;
    post_rst = 1'b1;
  endtask

  // Monitor: checks flow-control flags against model occupancy and pops on output accept.
  initial begin
    forever begin
      @(negedge clk); #2;
      if (reset_n) begin
        int   held;
        logic exp_rdy;
        held     = sb.size() - int'(pend);
        exp_rdy  = post_rst ? 1'b0 : (held < 2);
        post_rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
          chk($sformatf("d%0d in_ready", k), 32'(rdy[k]), 32'(exp_rdy));
          chk($sformatf("d%0d out_valid", k), 32'(ov[k]), 32'(held > 0));
          chk($sformatf("d%0d err_beat_count", k), 32'(cnt[k]), 32'(ecnt[k]));
          if (held > 0) begin
            chk($sformatf("d%0d out_data", k), od[k], sb[0].d);
            chk($sformatf("d%0d out_error", k), 32'(oe[k]), 32'(sb[0].e[k]));
            chk($sformatf("d%0d sop/eop/empty", k),
                32'({osop[k], oeop[k], oemp[k]}), 32'({sb[0].s, sb[0].p, sb[0].m}));
          end
        end
        if (held > 0 && out_ready) begin
          for (int k = 0; k < 3; k++)
            if (sb[0].e[k] && ecnt[k] < 65535) ecnt[k]++;
          void'(sb.pop_front());
        end
      end
    end
  end

  logic [5:0] errs [4] = '{6'b000010, 6'b000001, 6'b001111, 6'b100000};
  logic       exp0 [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  logic       exp1 [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  logic       stk  [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    logic a;
    do_reset();
    idle(1'b1);

    // Back-to-back stream, one-cycle latency, no bubbles
    for (int i = 0; i <= 8; i++) begin
      cycle(i < 8, 32'(i), 6'd0, i == 0, i == 7, 2'd0, 1'b1, a);
      if (i < 8) chk("stream in_ready", 32'(a), 1);
      if (i > 0) begin
        chk("stream out_valid", 32'(ov[0]), 1);
        chk("stream latency data", od[0], 32'(i - 1));
      end
    end
    idle(1'b1);

    // Backpressure: two beats fill the buffer, third waits
    cycle(1'b1, 32'h100, 6'd0, 1'b1, 1'b0, 2'd0, 1'b0, a);
    cycle(1'b1, 32'h101, 6'd0, 1'b0, 1'b0, 2'd1, 1'b0, a);
    cycle(1'b1, 32'h102, 6'd0, 1'b0, 1'b1, 2'd2, 1'b0, a);
    chk("backpressure third beat accepted", 32'(a), 0);
    chk("backpressure in_ready", 32'(rdy[0]), 0);
    send(32'h102, 6'd0, 1'b0, 1'b1, 1'b1);
    repeat (3) idle(1'b1);

    // Error mapping, single-beat packets
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) cycle(1'b1, 32'h200 + 32'(i), errs[i], 1'b1, 1'b1, 2'd0, 1'b1, a);
      else       idle(1'b1);
      if (i > 0) begin
        chk("map direct out_error", 32'(oe[0]), 32'(exp0[i-1]));
        chk("map masked-or out_error", 32'(oe[1]), 32'(exp1[i-1]));
        chk("map sticky single-beat out_error", 32'(oe[2]), 32'(exp0[i-1]));
      end
    end

    // Sticky accumulation: error on beat 2 of packet A, packet B clean
    do_reset();
    idle(1'b1);
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) cycle(1'b1, 32'h300 + 32'(i), (i == 1) ? 6'b000001 : 6'b000000,
                       (i % 4) == 0, (i % 4) == 3, 2'd3, 1'b1, a);
      else       idle(1'b1);
      if (i > 0) chk("sticky out_error", 32'(oe[2]), 32'(stk[i-1]));
    end
    idle(1'b1);
    chk("sticky err_beat_count", 32'(cnt[2]), 3);
    chk("direct err_beat_count", 32'(cnt[0]), 1);

    // Reset while full: nothing held survives
    cycle(1'b1, 32'h400, 6'h3f, 1'b1, 1'b0, 2'd0, 1'b0, a);
    cycle(1'b1, 32'h401, 6'h3f, 1'b0, 1'b0, 2'd0, 1'b0, a);
    idle(1'b0);
    chk("full before reset in_ready", 32'(rdy[0]), 0);
    do_reset();
    idle(1'b1);
    chk("after reset in_ready", 32'(rdy[0]), 1);
    chk("after reset out_valid", 32'(ov[0]), 0);
    repeat (3) idle(1'b1);

    // Random traffic with a reset in the middle
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      cycle(($urandom % 4) != 0, $urandom, 6'($urandom), ($urandom % 4) == 0,
            ($urandom % 4) == 0, 2'($urandom), ($urandom % 3) != 0, a);
    end

    repeat (6) idle(1'b1);
    chk("scoreboard drained", 32'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
